// File: rtl/first_counter_monitor_if.sv
// rtl/first_counter_monitor_if.sv - observed counter stimulus and outputs as seen by the monitor
interface first_counter_monitor_if #(
    parameter int WIDTH = 4
);
    logic             mon_reset;
    logic             mon_enable;
    logic [WIDTH-1:0] mon_count;
    logic             mon_ovf;

    modport master (
        output mon_reset,
        output mon_enable,
        output mon_count,
        output mon_ovf
    );

    modport slave (
        input mon_reset,
        input mon_enable,
        input mon_count,
        input mon_ovf
    );
endinterface

// File: rtl/first_counter_monitor.sv
// rtl/first_counter_monitor.sv - cycle-accurate checker for the first_counter with error statistics
module first_counter_monitor #(
    parameter int WIDTH       = 4,
    parameter int WRAP_CNT_W  = 8,
    parameter int CHECK_CNT_W = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    first_counter_monitor_if.slave mon,
    output logic [1:0]             state,
    output logic                   mismatch,
    output logic                   error,
    output logic [7:0]             err_count,
    output logic [WIDTH:0]         err_got,
    output logic [WIDTH:0]         err_exp,
    output logic [WRAP_CNT_W-1:0]  wrap_count,
    output logic [CHECK_CNT_W-1:0] check_count
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           st;
    logic [WIDTH-1:0] exp_cnt;
    logic             exp_ovf;
    logic [WIDTH:0]   got_val;
    logic [WIDTH:0]   exp_val;
    logic             differs;
    logic             at_max;

    assign got_val = {mon.mon_ovf, mon.mon_count};
    assign exp_val = {exp_ovf, exp_cnt};
    assign differs = (got_val != exp_val);
    assign at_max  = (exp_cnt == CNT_MAX);
    assign state   = st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= ST_IDLE;
            exp_cnt     <= '0;
            exp_ovf     <= 1'b0;
            mismatch    <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
            err_got     <= '0;
            err_exp     <= '0;
            wrap_count  <= '0;
            check_count <= '0;
        end else if (clr) begin
            st          <= ST_IDLE;
            exp_cnt     <= '0;
            exp_ovf     <= 1'b0;
            mismatch    <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
            err_got     <= '0;
            err_exp     <= '0;
            wrap_count  <= '0;
            check_count <= '0;
        end else begin
            case (st)
                ST_TRACK: begin
                    if (!(&check_count))
                        check_count <= check_count + 1'b1;
                    mismatch <= differs;
                    if (differs) begin
                        error <= 1'b1;
                        if (!(&err_count))
                            err_count <= err_count + 1'b1;
                        // Only the first divergence is captured; later ones just count.
                        if (!error) begin
                            err_got <= got_val;
                            err_exp <= exp_val;
                        end
                        if (STOP_ON_ERR != 0)
                            st <= ST_FAULT;
                    end
                    // The model advances from its own state so one bad sample does not cascade.
                    if (mon.mon_reset) begin
                        exp_cnt <= '0;
                        exp_ovf <= 1'b0;
                    end else begin
                        exp_cnt <= exp_cnt + {{(WIDTH-1){1'b0}}, mon.mon_enable};
                        exp_ovf <= exp_ovf | at_max;
                        if (mon.mon_enable && at_max && !(&wrap_count))
                            wrap_count <= wrap_count + 1'b1;
                    end
                end
                ST_FAULT: begin
                    mismatch <= 1'b0;
                end
                default: begin
                    mismatch <= 1'b0;
                    if (mon.mon_reset) begin
                        st      <= ST_TRACK;
                        exp_cnt <= '0;
                        exp_ovf <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_first_counter_monitor.sv
// tb/tb_first_counter_monitor.sv - randomized bench for first_counter_monitor against a behavioural model
module tb_first_counter_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clr;

    first_counter_monitor_if #(.WIDTH(4)) mon_if ();

    // index 0: STOP_ON_ERR=0, index 1: STOP_ON_ERR=1
    logic [1:0]  d_state [2];
    logic        d_mism  [2];
    logic        d_err   [2];
    logic [7:0]  d_ecnt  [2];
    logic [4:0]  d_got   [2];
    logic [4:0]  d_exp   [2];
    logic [7:0]  d_wrap  [2];
    logic [15:0] d_chk   [2];

    first_counter_monitor #(.STOP_ON_ERR(0)) dut_free (
        .clk(clk), .reset_n(reset_n), .clr(clr), .mon(mon_if),
        .state(d_state[0]), .mismatch(d_mism[0]), .error(d_err[0]), .err_count(d_ecnt[0]),
        .err_got(d_got[0]), .err_exp(d_exp[0]), .wrap_count(d_wrap[0]), .check_count(d_chk[0])
    );

    first_counter_monitor #(.STOP_ON_ERR(1)) dut_stop (
        .clk(clk), .reset_n(reset_n), .clr(clr), .mon(mon_if),
        .state(d_state[1]), .mismatch(d_mism[1]), .error(d_err[1]), .err_count(d_ecnt[1]),
        .err_got(d_got[1]), .err_exp(d_exp[1]), .wrap_count(d_wrap[1]), .check_count(d_chk[1])
    );

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: expected count is the number of enables since the last counter reset, mod 16.
    int m_st [2], m_nen [2], m_ecnt [2], m_wraps [2], m_checks [2], m_got [2], m_exp [2];
    bit m_ovf [2], m_mism [2], m_err [2];

    // Ideal counter that generates the observed outputs before corruption.
    int ic_cnt = 0;
    bit ic_ovf = 0;

    task automatic model_zero(input int k);
        m_st[k] = 0; m_nen[k] = 0; m_ovf[k] = 0; m_mism[k] = 0; m_err[k] = 0;
        m_ecnt[k] = 0; m_got[k] = 0; m_exp[k] = 0; m_wraps[k] = 0; m_checks[k] = 0;
    endtask

    task automatic model_edge();
        int e_val, g_val;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n || clr) begin
                model_zero(k);
            end else if (m_st[k] == 1) begin
                e_val = (m_ovf[k] ? 16 : 0) + (m_nen[k] % 16);
                g_val = (mon_if.mon_ovf ? 16 : 0) + int'(mon_if.mon_count);
                if (m_checks[k] < 65535) m_checks[k]++;
                m_mism[k] = (e_val != g_val);
                if (m_mism[k]) begin
                    if (!m_err[k]) begin
                        m_got[k] = g_val;
                        m_exp[k] = e_val;
                    end
                    m_err[k] = 1;
                    if (m_ecnt[k] < 255) m_ecnt[k]++;
                    if (k == 1) m_st[k] = 2;
                end
                if (mon_if.mon_reset) begin
                    m_nen[k] = 0;
                    m_ovf[k] = 0;
                end else begin
                    if (m_nen[k] % 16 == 15) begin
                        m_ovf[k] = 1;
                        if (mon_if.mon_enable && m_wraps[k] < 255) m_wraps[k]++;
                    end
                    m_nen[k] += int'(mon_if.mon_enable);
                end
            end else if (m_st[k] == 2) begin
                m_mism[k] = 0;
            end else begin
                m_mism[k] = 0;
                if (mon_if.mon_reset) begin
                    m_st[k] = 1;
                    m_nen[k] = 0;
                    m_ovf[k] = 0;
                end
            end
        end
        if (mon_if.mon_reset) begin
            ic_cnt = 0;
            ic_ovf = 0;
        end else begin
            if (ic_cnt == 15) ic_ovf = 1;
            ic_cnt = (ic_cnt + int'(mon_if.mon_enable)) % 16;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("state%0d", k), d_state[k], m_st[k]);
            check_eq($sformatf("mismatch%0d", k), d_mism[k], m_mism[k]);
            check_eq($sformatf("error%0d", k), d_err[k], m_err[k]);
            check_eq($sformatf("err_count%0d", k), d_ecnt[k], m_ecnt[k]);
            check_eq($sformatf("err_got%0d", k), d_got[k], m_got[k]);
            check_eq($sformatf("err_exp%0d", k), d_exp[k], m_exp[k]);
            check_eq($sformatf("wrap_count%0d", k), d_wrap[k], m_wraps[k]);
            check_eq($sformatf("check_count%0d", k), d_chk[k], m_checks[k]);
        end
    endtask

    // Drive one cycle of stimulus at negedge, advance the model at posedge, check at next negedge.
    task automatic step(input bit c, input bit r, input bit e, input logic [3:0] x, input bit kill_ovf);
        logic [3:0] cnt4;
        cnt4 = 4'(ic_cnt);
        clr = c;
        mon_if.mon_reset  = r;
        mon_if.mon_enable = e;
        mon_if.mon_count  = cnt4 ^ x;
        mon_if.mon_ovf    = kill_ovf ? 1'b0 : ic_ovf;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    int wrap_before;

    initial begin
        reset_n = 1'b0;
        clr = 1'b0;
        mon_if.mon_reset = 1'b0;
        mon_if.mon_enable = 1'b0;
        mon_if.mon_count = 4'd0;
        mon_if.mon_ovf = 1'b0;
        for (int k = 0; k < 2; k++) model_zero(k);
        @(negedge clk);

        // Reset held with random observed values, then release without a counter reset.
        repeat (3) step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        check_eq("reset_state", d_state[1], 0);
        reset_n = 1'b1;
        repeat (5) step(0, 0, 1'($urandom), 4'd0, 0);
        check_eq("idle_state", d_state[1], 0);
        check_eq("idle_checks", d_chk[1], 0);

        // Golden run
        step(0, 1, 0, 4'd0, 0);
        repeat (100) step(0, 0, 1, 4'd0, 0);
        check_eq("golden_wraps", d_wrap[1], 6);
        check_eq("golden_error", d_err[1], 0);
        check_eq("golden_checks", d_chk[1], 100);

        // Single corrupted sample: count 5 while the model expects 4
        step(0, 1, 0, 4'd0, 0);
        repeat (4) step(0, 0, 1, 4'd0, 0);
        step(0, 0, 1, 4'd1, 0);
        check_eq("bad5_mismatch", d_mism[1], 1);
        check_eq("bad5_got", d_got[1], 5'b00101);
        check_eq("bad5_exp", d_exp[1], 5'b00100);
        check_eq("bad5_state", d_state[1], 2);
        check_eq("bad5_errcnt", d_ecnt[1], 1);
        step(0, 0, 1, 4'd0, 0);
        check_eq("bad5_pulse_end", d_mism[1], 0);
        step(1, 0, 0, 4'd0, 0);

        // Wrap without overflow raised
        step(0, 1, 0, 4'd0, 0);
        repeat (15) step(0, 0, 1, 4'd0, 0);
        step(0, 0, 1, 4'd0, 0);
        step(0, 0, 1, 4'd0, 1);
        check_eq("noovf_exp", d_exp[1], 5'b10000);
        check_eq("noovf_got", d_got[1], 5'b00000);
        step(1, 0, 0, 4'd0, 0);

        // Hold at 15 with enable low: overflow rises, no wrap
        step(0, 1, 0, 4'd0, 0);
        repeat (15) step(0, 0, 1, 4'd0, 0);
        wrap_before = int'(d_wrap[1]);
        repeat (4) step(0, 0, 0, 4'd0, 0);
        check_eq("hold_wrap", d_wrap[1], wrap_before);
        check_eq("hold_error", d_err[1], 0);
        step(1, 0, 0, 4'd0, 0);

        // Saturating error counter on the free-running instance
        step(0, 1, 0, 4'd0, 0);
        repeat (300) step(0, 0, 1'($urandom), 4'($urandom_range(1, 15)), 0);
        check_eq("sat_errcnt", d_ecnt[0], 255);
        step(1, 1, 1, 4'd0, 0);
        check_eq("clr_state", d_state[0], 0);
        check_eq("clr_errcnt", d_ecnt[0], 0);
        check_eq("clr_got", d_got[0], 0);

        // Random mix
        repeat (300) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
                 ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
